// File: rtl/tpuv2_seq_ctrl.sv
// Host-facing TPU v2 controller: region decode, A/B row assembly, C clear/read, matmul sequencing.
// Optional feature macro: TPUV2_ACCUM_EN (CTRL bit1 ACCUM lets START skip the C clear).
module tpuv2_seq_ctrl #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8,
    parameter int ADDRW   = 16,
    parameter int DATAW   = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req,
    input  logic                       r_w,
    input  logic [ADDRW-1:0]           addr,
    input  logic [DATAW-1:0]           dataIn,
    output logic [DATAW-1:0]           dataOut,
    output logic                       rd_valid,
    output logic                       a_wr_en,
    output logic [$clog2(DIM)-1:0]     a_row,
    output logic [DIM*BITS_AB-1:0]     a_data,
    output logic                       b_wr_en,
    output logic [$clog2(DIM)-1:0]     b_row,
    output logic [DIM*BITS_AB-1:0]     b_data,
    output logic                       compute_en,
    output logic                       c_wr_en,
    output logic [$clog2(DIM)-1:0]     c_row,
    output logic [DIM*BITS_C-1:0]      c_data,
    input  logic [DIM*BITS_C-1:0]      c_in,
    output logic [1:0]                 dbg_state
);

    localparam int RW        = $clog2(DIM);
    localparam int OFFW      = ADDRW - 2;
    localparam int CHUNKS_AB = DIM * BITS_AB / DATAW;
    localparam int CHUNKS_C  = DIM * BITS_C / DATAW;
    localparam int RUN_LEN   = 3 * DIM - 2;
    localparam int CNTW      = $clog2(3 * DIM);

    localparam logic [OFFW-1:0] CAB_W    = OFFW'(CHUNKS_AB);
    localparam logic [OFFW-1:0] CAB_LAST = OFFW'(CHUNKS_AB - 1);
    localparam logic [OFFW-1:0] CC_W     = OFFW'(CHUNKS_C);
    localparam logic [OFFW-1:0] AB_LIM   = OFFW'(DIM * CHUNKS_AB);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state;
    logic [CNTW-1:0]        cnt;
    logic                   done;
    logic                   err;
    logic [DIM*BITS_AB-1:0] a_stage, b_stage;
    logic [DIM*BITS_AB-1:0] a_stage_nx, b_stage_nx;

    logic [1:0]      region;
    logic [OFFW-1:0] off;
    logic [OFFW-1:0] ab_chunk, c_chunk;
    logic [RW-1:0]   ab_row, host_c_row;
    logic            busy, wr, rd, a_ok, b_ok, ab_last;
    logic            ctrl_wr0, w1c, start_req, start_ok, err_set;
    logic            skip_clear, accum_bit;
    logic [3:0]      status;
    logic [DATAW-1:0] rdata;

    assign region     = addr[ADDRW-1:ADDRW-2];
    assign off        = addr[OFFW-1:0];
    assign ab_chunk   = off % CAB_W;
    assign c_chunk    = off % CC_W;
    assign ab_row     = RW'(off / CAB_W);
    assign host_c_row = RW'(off / CC_W);

    assign busy      = (state != S_IDLE);
    assign wr        = req & r_w;
    assign rd        = req & ~r_w;
    assign a_ok      = wr & (region == 2'd1) & ~busy & (off < AB_LIM);
    assign b_ok      = wr & (region == 2'd2) & ~busy & (off < AB_LIM);
    assign ab_last   = (ab_chunk == CAB_LAST);
    assign ctrl_wr0  = wr & (region == 2'd0) & (off == '0);
    assign w1c       = ctrl_wr0 & dataIn[2];
    assign start_req = ctrl_wr0 & dataIn[0];
    assign start_ok  = start_req & ~busy;
    // Any A/B write, START or C read attempted mid-run is flagged; CTRL reads never are.
    assign err_set   = busy & ((wr & ((region == 2'd1) | (region == 2'd2))) |
                               start_req | (rd & (region == 2'd3)));

`ifdef TPUV2_ACCUM_EN
    logic accum_q;
    always_ff @(posedge clk) begin
        if (!rst_n)        accum_q <= 1'b0;
        else if (ctrl_wr0) accum_q <= dataIn[1];
    end
    assign accum_bit  = accum_q;
    assign skip_clear = dataIn[1];
`else
    assign accum_bit  = 1'b0;
    assign skip_clear = 1'b0;
`endif

    assign status    = {accum_bit, err, done, busy};
    assign c_data    = '0;
    assign dbg_state = state;
    // The clear sequence owns the C row select; otherwise it follows the host C access.
    assign c_row     = (state == S_CLEAR) ? cnt[RW-1:0] :
                       (req && region == 2'd3) ? host_c_row : '0;

    always_comb begin
        a_stage_nx = a_stage;
        b_stage_nx = b_stage;
        for (int k = 0; k < CHUNKS_AB; k++) begin
            if (ab_chunk == OFFW'(k)) begin
                a_stage_nx[k*DATAW +: DATAW] = dataIn;
                b_stage_nx[k*DATAW +: DATAW] = dataIn;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (region)
            2'd0: if (off == '0) rdata = DATAW'(status);
            2'd3: begin
                if (!busy) begin
                    for (int k = 0; k < CHUNKS_C; k++) begin
                        if (c_chunk == OFFW'(k)) rdata = c_in[k*DATAW +: DATAW];
                    end
                end
            end
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            a_stage    <= '0;
            b_stage    <= '0;
            a_wr_en    <= 1'b0;
            a_row      <= '0;
            a_data     <= '0;
            b_wr_en    <= 1'b0;
            b_row      <= '0;
            b_data     <= '0;
            compute_en <= 1'b0;
            c_wr_en    <= 1'b0;
            dataOut    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            a_wr_en  <= 1'b0;
            b_wr_en  <= 1'b0;
            rd_valid <= rd;
            if (rd) dataOut <= rdata;

            if (a_ok) begin
                a_stage <= a_stage_nx;
                if (ab_last) begin
                    a_wr_en <= 1'b1;
                    a_row   <= ab_row;
                    a_data  <= a_stage_nx;
                end
            end
            if (b_ok) begin
                b_stage <= b_stage_nx;
                if (ab_last) begin
                    b_wr_en <= 1'b1;
                    b_row   <= ab_row;
                    b_data  <= b_stage_nx;
                end
            end

            err <= (err & ~w1c) | err_set;
            if (w1c) done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        done <= 1'b0;
                        cnt  <= '0;
                        if (skip_clear) begin
                            state      <= S_RUN;
                            compute_en <= 1'b1;
                        end else begin
                            state   <= S_CLEAR;
                            c_wr_en <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    if (cnt == CNTW'(DIM - 1)) begin
                        cnt        <= '0;
                        state      <= S_RUN;
                        c_wr_en    <= 1'b0;
                        compute_en <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (cnt == CNTW'(RUN_LEN - 1)) begin
                        cnt        <= '0;
                        state      <= S_DONE;
                        compute_en <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpuv2_seq_ctrl.sv
// Bench for tpuv2_seq_ctrl: directed scenarios plus random host traffic against a cycle-count model.
`timescale 1ns/1ps
module tb_tpuv2_seq_ctrl;

    localparam int BITS_AB = 8;
    localparam int BITS_C  = 16;
    localparam int DIM     = 8;
    localparam int ADDRW   = 16;
    localparam int DATAW   = 64;
    localparam int CAB     = DIM * BITS_AB / DATAW;
    localparam int CC      = DIM * BITS_C / DATAW;
    localparam int RW      = $clog2(DIM);
    localparam int RUN_LEN = 3 * DIM - 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   req = 1'b0;
    logic                   r_w = 1'b0;
    logic [ADDRW-1:0]       addr = '0;
    logic [DATAW-1:0]       dataIn = '0;
    logic [DATAW-1:0]       dataOut;
    logic                   rd_valid;
    logic                   a_wr_en, b_wr_en, compute_en, c_wr_en;
    logic [RW-1:0]          a_row, b_row, c_row;
    logic [DIM*BITS_AB-1:0] a_data, b_data;
    logic [DIM*BITS_C-1:0]  c_data, c_in;
    logic [1:0]             dbg_state;
    logic [DIM*BITS_C-1:0]  c_mem [DIM];

    tpuv2_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req(req), .r_w(r_w), .addr(addr), .dataIn(dataIn),
        .dataOut(dataOut), .rd_valid(rd_valid),
        .a_wr_en(a_wr_en), .a_row(a_row), .a_data(a_data),
        .b_wr_en(b_wr_en), .b_row(b_row), .b_data(b_data),
        .compute_en(compute_en), .c_wr_en(c_wr_en), .c_row(c_row), .c_data(c_data),
        .c_in(c_in), .dbg_state(dbg_state)
    );

    assign c_in = c_mem[c_row];

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: run progress counted in cycles since START was accepted (0 = idle).
    int             d = 0;
    int             clr_len = DIM;
    bit             m_done, m_err, m_accum;
    logic [DATAW-1:0] a_stage [CAB];
    logic [DATAW-1:0] b_stage [CAB];
    logic [DATAW-1:0] exp_q [$];
    logic [DATAW-1:0] last_dout;
    int             e_arow, e_brow;
    logic [DIM*BITS_AB-1:0] e_adata, e_bdata;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_clear(int dd);
        return dd >= 1 && dd <= clr_len;
    endfunction

    function automatic bit in_run(int dd);
        return dd > clr_len && dd <= clr_len + RUN_LEN;
    endfunction

    task automatic do_reset(input int n);
        rst_n = 1'b0; req = 1'b0; r_w = 1'b0; addr = '0; dataIn = '0;
        repeat (n) @(posedge clk);
        #1;
        d = 0; clr_len = DIM; m_done = 0; m_err = 0; m_accum = 0;
        for (int k = 0; k < CAB; k++) begin a_stage[k] = '0; b_stage[k] = '0; end
        exp_q.delete();
        last_dout = '0;
        check("rst_dataOut", dataOut, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_a_wr_en", a_wr_en, 0);
        check("rst_a_data", a_data, 0);
        check("rst_b_wr_en", b_wr_en, 0);
        check("rst_b_data", b_data, 0);
        check("rst_compute_en", compute_en, 0);
        check("rst_c_wr_en", c_wr_en, 0);
        check("rst_c_row", c_row, 0);
        check("rst_c_data", c_data, 0);
        rst_n = 1'b1;
    endtask

    // One host cycle: apply inputs, check combinational c_row, clock, update model, check registered outputs.
    task automatic cycle(input bit rq, input bit rw, input logic [ADDRW-1:0] ad, input logic [DATAW-1:0] di);
        int region, off, exp_crow;
        bit busy_b, w1c, st, errset, ab_ok, e_awr, e_bwr, is_rd;
        logic [DIM*BITS_C-1:0] row_v;
        logic [DATAW-1:0] e_rd;
        req = rq; r_w = rw; addr = ad; dataIn = di;
        region = int'(ad[ADDRW-1:ADDRW-2]);
        off    = int'(ad[ADDRW-3:0]);
        busy_b = (d != 0);
        is_rd  = rq && !rw;
        #1;
        if (in_clear(d))                exp_crow = d - 1;
        else if (rq && region == 3)     exp_crow = (off / CC) % DIM;
        else                            exp_crow = 0;
        check("c_row", c_row, exp_crow);

        if (is_rd) begin
            e_rd = '0;
            if (region == 0 && off == 0)
                e_rd = {60'd0, m_accum, m_err, m_done, busy_b};
            else if (region == 3 && !busy_b) begin
                row_v = c_mem[(off / CC) % DIM];
                e_rd = DATAW'(row_v >> ((off % CC) * DATAW));
            end
            exp_q.push_back(e_rd);
        end

        w1c    = rq && rw && region == 0 && off == 0 && di[2];
        st     = rq && rw && region == 0 && off == 0 && di[0];
        errset = busy_b && rq && ((rw && (region == 1 || region == 2)) || st || (!rw && region == 3));
        ab_ok  = rq && rw && !busy_b && off < DIM * CAB;
        e_awr = 0; e_bwr = 0;
        if (ab_ok && region == 1) begin
            a_stage[off % CAB] = di;
            if (off % CAB == CAB - 1) begin
                e_awr = 1; e_arow = off / CAB;
                for (int k = 0; k < CAB; k++) e_adata[k*DATAW +: DATAW] = a_stage[k];
            end
        end
        if (ab_ok && region == 2) begin
            b_stage[off % CAB] = di;
            if (off % CAB == CAB - 1) begin
                e_bwr = 1; e_brow = off / CAB;
                for (int k = 0; k < CAB; k++) e_bdata[k*DATAW +: DATAW] = b_stage[k];
            end
        end
        m_err = (m_err && !w1c) || errset;
        if (w1c) m_done = 0;
        if (d != 0) begin
            d++;
            if (d == clr_len + RUN_LEN + 2) begin d = 0; m_done = 1; end
        end else if (st) begin
            d = 1; m_done = 0; clr_len = DIM;
`ifdef TPUV2_ACCUM_EN
            if (di[1]) clr_len = 0;
`endif
        end
`ifdef TPUV2_ACCUM_EN
        if (rq && rw && region == 0 && off == 0) m_accum = di[1];
`endif

        @(posedge clk);
        #1;
        check("rd_valid", rd_valid, is_rd);
        if (is_rd) last_dout = exp_q.pop_front();
        check("dataOut", dataOut, last_dout);
        check("a_wr_en", a_wr_en, e_awr);
        if (e_awr) begin
            check("a_row", a_row, e_arow);
            check("a_data", a_data, e_adata);
        end
        check("b_wr_en", b_wr_en, e_bwr);
        if (e_bwr) begin
            check("b_row", b_row, e_brow);
            check("b_data", b_data, e_bdata);
        end
        check("c_wr_en", c_wr_en, in_clear(d));
        check("compute_en", compute_en, in_run(d));
        check("c_data", c_data, 0);
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0);
    endtask

    task automatic wait_run_end();
        for (int i = 0; i < 4 * DIM + 8 && d != 0; i++) cycle(0, 0, '0, '0);
    endtask

    task automatic read_status_expect(input logic [DATAW-1:0] exp);
        cycle(1, 0, 16'h0000, '0);
        check("status_direct", dataOut, exp);
    endtask

    initial begin
        for (int r = 0; r < DIM; r++) c_mem[r] = {$urandom, $urandom, $urandom, $urandom};

        do_reset(2);
        read_status_expect(64'h0);

        cycle(1, 1, 16'h4003, 64'h0807060504030201);
        check("a_row_direct", a_row, 3);
        check("a_data_direct", a_data, 64'h0807060504030201);

        cycle(1, 1, 16'h0000, 64'h1);
        wait_run_end();
        read_status_expect(64'h2);

        cycle(1, 1, 16'h0000, 64'h1);
        idle(3);
        cycle(1, 1, 16'h8001, 64'hdeadbeef);
        cycle(1, 1, 16'h0000, 64'h1);
        wait_run_end();
        read_status_expect(64'h6);
        cycle(1, 1, 16'h0000, 64'h4);
        read_status_expect(64'h0);

        c_mem[2] = {64'h1111111111111111, 64'h2222222222222222};
        cycle(1, 0, 16'hC005, '0);
        check("c_read_direct", dataOut, 64'h1111111111111111);

        cycle(1, 1, 16'h0000, 64'h1);
        idle(DIM + 5);
        do_reset(1);
        cycle(1, 1, 16'h0000, 64'h1);
        wait_run_end();
        read_status_expect(64'h2);

`ifdef TPUV2_ACCUM_EN
        cycle(1, 1, 16'h0000, 64'h3);
        check("accum_compute_en", compute_en, 1);
        check("accum_no_clear", c_wr_en, 0);
        wait_run_end();
        read_status_expect(64'hA);
`endif

        for (int i = 0; i < 1500; i++) begin
            int region, off, kind;
            logic [DATAW-1:0] di;
            if ($urandom_range(0, 399) == 0) do_reset(1);
            if ($urandom_range(0, 49) == 0) c_mem[$urandom_range(0, DIM - 1)] = {$urandom, $urandom, $urandom, $urandom};
            kind   = $urandom_range(0, 9);
            region = $urandom_range(0, 3);
            di     = {$urandom, $urandom};
            case (region)
                0: begin off = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0; di = DATAW'($urandom_range(0, 7)); end
                3: off = $urandom_range(0, DIM * CC - 1);
                default: off = $urandom_range(0, DIM * CAB + 2);
            endcase
            if (kind < 3) cycle(0, 0, '0, '0);
            else cycle(1, kind < 7, {region[1:0], 14'(off)}, di);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
